// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg
//   ID->EX pipeline register with a valid/ready handshake and a one-entry skid
//   buffer, so that in_ready depends on registered state only. Supports flush
//   (bubble injection) and counts back-pressure cycles in a saturating counter.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          synchronous reset, active-low
//   flush        squash held instruction(s) and any same-cycle input
//   in_valid     ID presents a valid instruction
//   in_ready     register can accept (decoded from state only)
//   pc_ID, imm_in, rs1_data, rs2_data, rd_addr   ID payload
//   out_valid    EX payload valid
//   out_ready    EX consumes payload this cycle
//   pc_EX, imm_ex, rs1_data_reg, rs2_data_reg, rd_addr_ex   EX payload
//   stall_cnt    saturating count of cycles with out_valid=1 and out_ready=0
module id_ex_pipe_reg #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    pc_ID,
  input  logic [XLEN-1:0]    imm_in,
  input  logic [XLEN-1:0]    rs1_data,
  input  logic [XLEN-1:0]    rs2_data,
  input  logic [RADDR_W-1:0] rd_addr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    pc_EX,
  output logic [XLEN-1:0]    imm_ex,
  output logic [XLEN-1:0]    rs1_data_reg,
  output logic [XLEN-1:0]    rs2_data_reg,
  output logic [RADDR_W-1:0] rd_addr_ex,
  output logic [CNT_W-1:0]   stall_cnt
);

  typedef enum logic [1:0] {StEmpty, StMain, StFull} state_e;

  state_e               r_state;

  // Main entry drives the EX outputs directly.
  logic [XLEN-1:0]      r_main_pc;
  logic [XLEN-1:0]      r_main_imm;
  logic [XLEN-1:0]      r_main_rs1;
  logic [XLEN-1:0]      r_main_rs2;
  logic [RADDR_W-1:0]   r_main_rd;

  // Skid entry catches the one instruction accepted while EX is stalled.
  logic [XLEN-1:0]      r_skid_pc;
  logic [XLEN-1:0]      r_skid_imm;
  logic [XLEN-1:0]      r_skid_rs1;
  logic [XLEN-1:0]      r_skid_rs2;
  logic [RADDR_W-1:0]   r_skid_rd;

  logic [CNT_W-1:0]     r_stall_cnt;

  logic                 w_accept;
  logic                 w_release;
  logic                 w_stall;

  assign out_valid = (r_state != StEmpty);
  assign in_ready  = (r_state != StFull);
  assign w_accept  = in_valid & in_ready;
  assign w_release = out_valid & out_ready;
  assign w_stall   = out_valid & ~out_ready;

  assign pc_EX        = r_main_pc;
  assign imm_ex       = r_main_imm;
  assign rs1_data_reg = r_main_rs1;
  assign rs2_data_reg = r_main_rs2;
  assign rd_addr_ex   = r_main_rd;
  assign stall_cnt    = r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= StEmpty;
      r_main_pc   <= '0;
      r_main_imm  <= '0;
      r_main_rs1  <= '0;
      r_main_rs2  <= '0;
      r_main_rd   <= '0;
      r_skid_pc   <= '0;
      r_skid_imm  <= '0;
      r_skid_rs1  <= '0;
      r_skid_rs2  <= '0;
      r_skid_rd   <= '0;
      r_stall_cnt <= '0;
    end else begin
      // Counts regardless of flush; only reset clears it.
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end

      if (flush) begin
        // Bubble: drop everything, including a same-cycle accept. Forcing rd to
        // x0 keeps hazard logic from matching on the squashed instruction.
        r_state   <= StEmpty;
        r_main_rd <= '0;
      end else begin
        case (r_state)
          StEmpty: begin
            if (w_accept) begin
              r_main_pc  <= pc_ID;
              r_main_imm <= imm_in;
              r_main_rs1 <= rs1_data;
              r_main_rs2 <= rs2_data;
              r_main_rd  <= rd_addr;
              r_state    <= StMain;
            end
          end
          StMain: begin
            if (w_accept && w_release) begin
              r_main_pc  <= pc_ID;
              r_main_imm <= imm_in;
              r_main_rs1 <= rs1_data;
              r_main_rs2 <= rs2_data;
              r_main_rd  <= rd_addr;
            end else if (w_release) begin
              r_state <= StEmpty;
            end else if (w_accept) begin
              r_skid_pc  <= pc_ID;
              r_skid_imm <= imm_in;
              r_skid_rs1 <= rs1_data;
              r_skid_rs2 <= rs2_data;
              r_skid_rd  <= rd_addr;
              r_state    <= StFull;
            end
          end
          StFull: begin
            if (w_release) begin
              r_main_pc  <= r_skid_pc;
              r_main_imm <= r_skid_imm;
              r_main_rs1 <= r_skid_rs1;
              r_main_rs2 <= r_skid_rs2;
              r_main_rd  <= r_skid_rd;
              r_state    <= StMain;
            end
          end
          default: r_state <= StEmpty;
        endcase
      end
    end
  end

endmodule
